// File: rtl/uart_word_tx.sv
// uart_word_tx: serializes a 32-bit word as four 8N1 UART frames, least-significant
// byte first, with a built-in baud-rate generator.
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   BAUD       line rate in bit/s; CLKS_PER_BIT = CLK_FREQ / BAUD (must be >= 2)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   word_valid  word_data holds a word to send
//   word_data   word to send; [7:0] is transmitted first
//   word_ready  a word presented now is accepted at the next rising edge
//   txd         UART serial out, idle/mark = 1
//   busy        a word is being transmitted
//   byte_idx    index of the byte currently on the line (4 = checksum frame)
//
// Optional feature: define UART_WORD_TX_CHECKSUM_EN to append a fifth frame carrying
// the XOR of the four data bytes (50 bit-times per word instead of 40).

module uart_word_tx #(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    output logic        word_ready,
    output logic        txd,
    output logic        busy,
    output logic [2:0]  byte_idx
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_WORD_TX_CHECKSUM_EN
    localparam int unsigned SR_W      = 40;
    localparam logic [2:0]  LAST_BYTE = 3'd4;
`else
    localparam int unsigned SR_W      = 32;
    localparam logic [2:0]  LAST_BYTE = 3'd3;
`endif

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  baud_cnt_q;
    logic [2:0]        bit_cnt_q;
    logic [SR_W-1:0]   shift_q;
    logic              txd_q;
    logic              busy_q;
    logic [2:0]        byte_idx_q;

    logic              bit_done;
    logic              last_byte;
    logic              accept;
    logic [2:0]        next_bit;
    logic [SR_W-1:0]   load_word;

    assign bit_done  = (baud_cnt_q == CNT_LAST);
    assign last_byte = (byte_idx_q == LAST_BYTE);
    assign next_bit  = bit_cnt_q + 3'd1;

    // Ready is also raised in the final cycle of the last stop bit so a waiting word
    // starts its start bit right where the stop bit ends, with no idle gap.
    assign word_ready = (state_q == StIdle) ||
                        ((state_q == StStop) && bit_done && last_byte);
    assign accept     = word_valid && word_ready;

`ifdef UART_WORD_TX_CHECKSUM_EN
    assign load_word = {word_data[31:24] ^ word_data[23:16] ^ word_data[15:8] ^ word_data[7:0],
                        word_data};
`else
    assign load_word = word_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            byte_idx_q <= '0;
        end else if (accept) begin
            // Covers both a fresh word from idle and a back-to-back word at end of stop.
            state_q    <= StStart;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= load_word;
            txd_q      <= 1'b0;
            busy_q     <= 1'b1;
            byte_idx_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    txd_q  <= 1'b1;
                    busy_q <= 1'b0;
                end
                StStart: begin
                    if (bit_done) begin
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        txd_q      <= shift_q[0];
                        state_q    <= StData;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (bit_done) begin
                        baud_cnt_q <= '0;
                        if (bit_cnt_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            bit_cnt_q <= next_bit;
                            txd_q     <= shift_q[next_bit];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (bit_done) begin
                        baud_cnt_q <= '0;
                        if (!last_byte) begin
                            byte_idx_q <= byte_idx_q + 3'd1;
                            shift_q    <= shift_q >> 8;
                            txd_q      <= 1'b0;
                            state_q    <= StStart;
                        end else begin
                            txd_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign txd      = txd_q;
    assign busy     = busy_q;
    assign byte_idx = byte_idx_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Testbench for uart_word_tx at CLK_FREQ=1000, BAUD=100 (10 clocks per bit).
// A line monitor decodes every frame and checks it against a scoreboard queue that
// the stimulus fills when it presents a word.

module tb_uart_word_tx;

    localparam int CPB = 10;
`ifdef UART_WORD_TX_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam int WORD_CYC = NB * 10 * CPB;

    logic        clk;
    logic        rst_n;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_ready;
    logic        txd;
    logic        busy;
    logic [2:0]  byte_idx;

    uart_word_tx #(
        .CLK_FREQ (1000),
        .BAUD     (100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .txd        (txd),
        .busy       (busy),
        .byte_idx   (byte_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  e0, e1, e2, e3;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [2:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   start_q[$];
    int   compared  = 0;
    int   failed    = 0;
    int   frames    = 0;
    int   rst_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic push_word(input vec_t v);
        exp_q.push_back('{data: v.e0, idx: 3'd0});
        exp_q.push_back('{data: v.e1, idx: 3'd1});
        exp_q.push_back('{data: v.e2, idx: 3'd2});
        exp_q.push_back('{data: v.e3, idx: 3'd3});
`ifdef UART_WORD_TX_CHECKSUM_EN
        exp_q.push_back('{data: v.e0 ^ v.e1 ^ v.e2 ^ v.e3, idx: 3'd4});
`endif
    endtask

    // Decode one frame; called at the first negedge that shows the start bit.
    task automatic decode_frame();
        int         snap;
        int         t0;
        logic [7:0] d;
        logic [2:0] idx_seen;
        logic       start_bit;
        logic       stop_bit;
        exp_t       e;
        snap = rst_count;
        t0   = cycle;
        repeat (CPB / 2 - 1) @(negedge clk);
        start_bit = txd;
        idx_seen  = byte_idx;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            d[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        stop_bit = txd;
        if (snap != rst_count) return;  // frame cut short by reset
        frames++;
        check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("start_bit", 32'(start_bit), 32'd0);
            check("stop_bit", 32'(stop_bit), 32'd1);
            check("frame_data", 32'(d), 32'(e.data));
            check("frame_byte_idx", 32'(idx_seen), 32'(e.idx));
            if (e.idx == 3'd0) start_q.push_back(t0);
        end
    endtask

    initial begin : line_monitor
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && txd === 1'b0) decode_frame();
        end
    end

    task automatic wait_ready(input int limit);
        int n = 0;
        while (word_ready !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(word_ready), 32'd1);
    endtask

    task automatic send_word(input vec_t v);
        int n;
        wait_ready(2 * WORD_CYC);
        push_word(v);
        word_data  = v.word;
        word_valid = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        word_data  = $urandom();
        check("accept_latency", 32'({txd, busy, word_ready}), 32'b010);
        n = 1;
        while (word_ready !== 1'b1 && n < WORD_CYC + 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_return", 32'(n), 32'(WORD_CYC));
        repeat (2) @(negedge clk);
        check("back_to_idle", 32'({txd, busy, word_ready}), 32'b101);
    endtask

    vec_t vecs[5];
    vec_t v_a5, v_ff, v_held, v_abort, v_dead;

    initial begin : watchdog
        #2000000;
        failed++;
        $display("FAIL watchdog: got timeout, required end of test");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        int f0;
        vecs[0] = '{32'h44332211, 8'h11, 8'h22, 8'h33, 8'h44};
        vecs[1] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[3] = '{32'h80017F01, 8'h01, 8'h7F, 8'h01, 8'h80};
        vecs[4] = '{32'hC3A55A3C, 8'h3C, 8'h5A, 8'hA5, 8'hC3};
        v_a5    = '{32'hA5A5A5A5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        v_ff    = '{32'h0000FFFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
        v_held  = '{32'h12345678, 8'h78, 8'h56, 8'h34, 8'h12};
        v_abort = '{32'h0BADF00D, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
        v_dead  = '{32'hDEADBEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

        rst_n      = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({txd, word_ready, busy, byte_idx}), 32'b110_000);
        rst_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_outputs", 32'({txd, word_ready, busy}), 32'b110);
        end

        for (int i = 0; i < 5; i++) send_word(vecs[i]);

        // Back-to-back words with word_valid held high.
        start_q.delete();
        wait_ready(2 * WORD_CYC);
        push_word(v_a5);
        word_data  = v_a5.word;
        word_valid = 1'b1;
        @(negedge clk);
        word_data = v_ff.word;
        push_word(v_ff);
        n = 1;
        while (word_ready !== 1'b1 && n < WORD_CYC + 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_ready", 32'(n), 32'(WORD_CYC));
        @(negedge clk);
        word_valid = 1'b0;
        check("b2b_no_gap", 32'({txd, busy}), 32'b01);
        repeat (WORD_CYC + 20) @(negedge clk);
        check("b2b_words", 32'(start_q.size()), 32'd2);
        if (start_q.size() == 2) check("b2b_spacing", 32'(start_q[1] - start_q[0]), 32'(WORD_CYC));

        // Request while busy is ignored and word_data changes do not leak in.
        f0 = frames;
        wait_ready(2 * WORD_CYC);
        push_word(v_held);
        word_data  = v_held.word;
        word_valid = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        repeat (50) @(negedge clk);
        word_data  = 32'hCAFEF00D;
        word_valid = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        wait_ready(2 * WORD_CYC);
        repeat (200) @(negedge clk);
        check("busy_req_frames", 32'(frames - f0), 32'(NB));
        check("busy_req_drained", 32'(exp_q.size()), 32'd0);

        // Reset during bit 3 of byte 1 (byte 1 = 0xF0, so the line is low there).
        wait_ready(2 * WORD_CYC);
        push_word(v_abort);
        word_data  = v_abort.word;
        word_valid = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        repeat (10 * CPB + 4 * CPB + 4) @(negedge clk);
        check("pre_reset_line", 32'(txd), 32'd0);
        rst_count++;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("reset_txd_async", 32'(txd), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_state", 32'({txd, word_ready, busy, byte_idx}), 32'b110_000);
        repeat (150) @(negedge clk);
        check("post_reset_idle", 32'({txd, busy}), 32'b10);
        send_word(v_dead);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
